// File: rtl/param_regfile_sb.sv
// Parametrised register file with two combinational read ports, one write port and a
// per-register busy scoreboard for RAW hazard stalls. Optional macro: REGFILE_BYPASS_EN.
module param_regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_markBusy,
    input  logic [ADDR_WIDTH-1:0] ctrl_busyReg,
    output logic                  busy_readRegA,
    output logic                  busy_readRegB,
    output logic [ADDR_WIDTH:0]   busy_count
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busyNext;
    logic [ADDR_WIDTH:0]   countNext;
    logic                  writeValid;
    logic                  markValid;

    assign writeValid = ctrl_writeEnable && (ctrl_writeReg != '0);
    assign markValid  = ctrl_markBusy && (ctrl_busyReg != '0);

    // A freshly issued producer outranks a retiring write to the same register.
    always_comb begin
        busyNext = busy;
        if (writeValid) begin
            busyNext[ctrl_writeReg] = 1'b0;
        end
        if (markValid) begin
            busyNext[ctrl_busyReg] = 1'b1;
        end
        busyNext[0] = 1'b0;
    end

    always_comb begin
        countNext = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            countNext = countNext + {{ADDR_WIDTH{1'b0}}, busyNext[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (writeValid) begin
                regs[ctrl_writeReg] <= data_writeReg;
            end
            busy       <= busyNext;
            busy_count <= countNext;
        end
    end

    // Index 0 is forced to zero here too, so it never depends on regs[0] contents.
    always_comb begin
        data_readRegA = (ctrl_readRegA == '0) ? '0 : regs[ctrl_readRegA];
        data_readRegB = (ctrl_readRegB == '0) ? '0 : regs[ctrl_readRegB];
        busy_readRegA = busy[ctrl_readRegA];
        busy_readRegB = busy[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
        if (writeValid && (ctrl_writeReg == ctrl_readRegA)) begin
            data_readRegA = data_writeReg;
            busy_readRegA = markValid && (ctrl_busyReg == ctrl_readRegA);
        end
        if (writeValid && (ctrl_writeReg == ctrl_readRegB)) begin
            data_readRegB = data_writeReg;
            busy_readRegB = markValid && (ctrl_busyReg == ctrl_readRegB);
        end
`endif
    end

endmodule

// File: tb/tb_param_regfile_sb.sv
// Directed self-checking bench for param_regfile_sb: default 32x32 instance plus a 16-bit,
// 8-register instance; bypass expectations follow REGFILE_BYPASS_EN.
module tb_param_regfile_sb;

    logic        clock = 1'b0;
    logic        ctrlReset;

    logic        we;
    logic [4:0]  wReg;
    logic [31:0] wData;
    logic [4:0]  rA, rB;
    logic [31:0] dA, dB;
    logic        mark;
    logic [4:0]  bReg;
    logic        bA, bB;
    logic [5:0]  count;

    logic        sWe;
    logic [2:0]  sWReg;
    logic [15:0] sWData;
    logic [2:0]  sRA, sRB;
    logic [15:0] sDA, sDB;
    logic        sMark;
    logic [2:0]  sBReg;
    logic        sBA, sBB;
    logic [3:0]  sCount;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    param_regfile_sb dut (
        .clock(clock), .ctrl_reset(ctrlReset),
        .ctrl_writeEnable(we), .ctrl_writeReg(wReg), .data_writeReg(wData),
        .ctrl_readRegA(rA), .ctrl_readRegB(rB),
        .data_readRegA(dA), .data_readRegB(dB),
        .ctrl_markBusy(mark), .ctrl_busyReg(bReg),
        .busy_readRegA(bA), .busy_readRegB(bB), .busy_count(count)
    );

    param_regfile_sb #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dutSmall (
        .clock(clock), .ctrl_reset(ctrlReset),
        .ctrl_writeEnable(sWe), .ctrl_writeReg(sWReg), .data_writeReg(sWData),
        .ctrl_readRegA(sRA), .ctrl_readRegB(sRB),
        .data_readRegA(sDA), .data_readRegB(sDB),
        .ctrl_markBusy(sMark), .ctrl_busyReg(sBReg),
        .busy_readRegA(sBA), .busy_readRegB(sBB), .busy_count(sCount)
    );

    // Inputs change 1ns after the rising edge so they are stable well before the next one.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        ctrlReset = 1'b1;
        step();
        ctrlReset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rA = 5'(i);
            rB = 5'(31 - i);
            #1;
            total++;
            if (dA !== 32'h0 || dB !== 32'h0) begin
                bad++;
                $display("[TB] FAIL reset_data idx=%0d got A=%h B=%h want 0", i, dA, dB);
            end
            total++;
            if (bA !== 1'b0 || bB !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_busy idx=%0d got A=%b B=%b want 0", i, bA, bB);
            end
        end
        total++;
        if (count !== 6'd0) begin
            bad++;
            $display("[TB] FAIL reset_count got=%0d want=0", count);
        end
        total++;
        if (sCount !== 4'd0) begin
            bad++;
            $display("[TB] FAIL reset_count_small got=%0d want=0", sCount);
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; wReg = 5'd5; wData = 32'hDEADBEEF;
        step();
        we = 1'b0; rA = 5'd5; rB = 5'd5;
        #1;
        total++;
        if (dA !== 32'hDEADBEEF || dB !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL write_r5 got A=%h B=%h want deadbeef", dA, dB);
        end
        we = 1'b1; wReg = 5'd0; wData = 32'h12345678;
        step();
        we = 1'b0; rA = 5'd0; rB = 5'd5;
        #1;
        total++;
        if (dA !== 32'h0) begin
            bad++;
            $display("[TB] FAIL write_r0 got=%h want=0", dA);
        end
        total++;
        if (dB !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL r5_kept got=%h want=deadbeef", dB);
        end
    endtask

    task automatic test_scoreboard();
        mark = 1'b1; bReg = 5'd7;
        step();
        mark = 1'b0; rA = 5'd7; rB = 5'd0;
        #1;
        total++;
        if (bA !== 1'b1 || count !== 6'd1) begin
            bad++;
            $display("[TB] FAIL mark_r7 got busy=%b count=%0d want busy=1 count=1", bA, count);
        end
        mark = 1'b1; bReg = 5'd0;
        step();
        mark = 1'b0;
        #1;
        total++;
        if (bB !== 1'b0 || count !== 6'd1) begin
            bad++;
            $display("[TB] FAIL mark_r0 got busy=%b count=%0d want busy=0 count=1", bB, count);
        end
        we = 1'b1; wReg = 5'd7; wData = 32'hA5;
        step();
        we = 1'b0;
        #1;
        total++;
        if (bA !== 1'b0 || count !== 6'd0 || dA !== 32'hA5) begin
            bad++;
            $display("[TB] FAIL write_clears_r7 got busy=%b count=%0d data=%h want 0 0 a5", bA, count, dA);
        end
        we = 1'b1; wReg = 5'd7; wData = 32'h55; mark = 1'b1; bReg = 5'd7;
        step();
        we = 1'b0; mark = 1'b0;
        #1;
        total++;
        if (bA !== 1'b1 || count !== 6'd1 || dA !== 32'h55) begin
            bad++;
            $display("[TB] FAIL mark_wins_r7 got busy=%b count=%0d data=%h want 1 1 55", bA, count, dA);
        end
    endtask

    task automatic test_saturation();
        for (int i = 1; i < 32; i++) begin
            mark = 1'b1; bReg = 5'(i);
            step();
        end
        mark = 1'b0;
        #1;
        total++;
        if (count !== 6'd31) begin
            bad++;
            $display("[TB] FAIL saturate got=%0d want=31", count);
        end
        mark = 1'b1; bReg = 5'd3;
        step();
        mark = 1'b0; rA = 5'd3;
        #1;
        total++;
        if (count !== 6'd31 || bA !== 1'b1) begin
            bad++;
            $display("[TB] FAIL remark_r3 got count=%0d busy=%b want 31 1", count, bA);
        end
        ctrlReset = 1'b1; we = 1'b1; wReg = 5'd9; wData = 32'h77;
        step();
        ctrlReset = 1'b0; we = 1'b0; rA = 5'd9; rB = 5'd5;
        #1;
        total++;
        if (dA !== 32'h0 || bA !== 1'b0 || count !== 6'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid got data=%h busy=%b count=%0d want 0 0 0", dA, bA, count);
        end
        total++;
        if (dB !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_mid_r5 got=%h want=0", dB);
        end
    endtask

    task automatic test_bypass();
        logic [31:0] expData;
        logic        expBusy;
        we = 1'b1; wReg = 5'd12; wData = 32'h1111;
        step();
        we = 1'b0; mark = 1'b1; bReg = 5'd12;
        step();
        mark = 1'b0;
        we = 1'b1; wReg = 5'd12; wData = 32'hCAFE; rA = 5'd12; rB = 5'd0;
        #1;
`ifdef REGFILE_BYPASS_EN
        expData = 32'hCAFE; expBusy = 1'b0;
`else
        expData = 32'h1111; expBusy = 1'b1;
`endif
        total++;
        if (dA !== expData || bA !== expBusy) begin
            bad++;
            $display("[TB] FAIL same_cycle_r12 got data=%h busy=%b want %h %b", dA, bA, expData, expBusy);
        end
        step();
        we = 1'b0;
        #1;
        total++;
        if (dA !== 32'hCAFE || bA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL next_cycle_r12 got data=%h busy=%b want cafe 0", dA, bA);
        end
        we = 1'b1; wReg = 5'd12; wData = 32'hBEEF; mark = 1'b1; bReg = 5'd12; rB = 5'd12;
        #1;
`ifdef REGFILE_BYPASS_EN
        expData = 32'hBEEF; expBusy = 1'b1;
`else
        expData = 32'hCAFE; expBusy = 1'b0;
`endif
        total++;
        if (dB !== expData || bB !== expBusy) begin
            bad++;
            $display("[TB] FAIL bypass_mark_r12 got data=%h busy=%b want %h %b", dB, bB, expData, expBusy);
        end
        step();
        we = 1'b1; wReg = 5'd0; wData = 32'hFFFF; mark = 1'b0; rA = 5'd0;
        #1;
        total++;
        if (dA !== 32'h0 || bA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL no_bypass_r0 got data=%h busy=%b want 0 0", dA, bA);
        end
        total++;
        if (dB !== 32'hBEEF || bB !== 1'b1) begin
            bad++;
            $display("[TB] FAIL after_mark_r12 got data=%h busy=%b want beef 1", dB, bB);
        end
        step();
        we = 1'b0;
    endtask

    task automatic test_params();
        sWe = 1'b1; sWReg = 3'd7; sWData = 16'hFFFF;
        step();
        sWe = 1'b0; sRA = 3'd7; sRB = 3'd0;
        #1;
        total++;
        if (sDA !== 16'hFFFF || sDB !== 16'h0) begin
            bad++;
            $display("[TB] FAIL small_r7 got A=%h B=%h want ffff 0", sDA, sDB);
        end
        for (int i = 1; i < 8; i++) begin
            sMark = 1'b1; sBReg = 3'(i);
            step();
        end
        sMark = 1'b1; sBReg = 3'd2;
        step();
        sMark = 1'b0;
        #1;
        total++;
        if (sCount !== 4'd7 || sBA !== 1'b1 || sBB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL small_saturate got count=%0d bA=%b bB=%b want 7 1 0", sCount, sBA, sBB);
        end
    endtask

    initial begin
        ctrlReset = 1'b0;
        we = 1'b0; wReg = '0; wData = '0; rA = '0; rB = '0; mark = 1'b0; bReg = '0;
        sWe = 1'b0; sWReg = '0; sWData = '0; sRA = '0; sRB = '0; sMark = 1'b0; sBReg = '0;
        #1;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_saturation();
        test_bypass();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
